// File: rtl/traffic_phase_ctrl.sv
// N-phase traffic-light controller: latches approach demand, grants green round-robin and
// sequences timed green / yellow / all-red against an external tick strobe.
module traffic_phase_ctrl #(
    parameter int unsigned N_PHASES  = 4,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 16,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [N_PHASES-1:0]         req,
    output logic [3*N_PHASES-1:0]       lamps,
    output logic [$clog2(N_PHASES)-1:0] phase,
    output logic [1:0]                  state
);

    localparam int unsigned PW = $clog2(N_PHASES);

    localparam logic [CNT_W-1:0] GreenMinM1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GreenMaxM1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YellowM1   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AllredM1   = CNT_W'(ALLRED_T - 1);

    localparam logic [3*N_PHASES-1:0] AllRed = {N_PHASES{3'b001}};

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGreen  = 2'b01,
        StYellow = 2'b10,
        StAllred = 2'b11
    } state_e;

    state_e                state_q;
    logic [PW-1:0]         phase_q;
    logic [PW-1:0]         last_q;
    logic [N_PHASES-1:0]   pending_q;
    logic [CNT_W-1:0]      timer_q;
    logic [3*N_PHASES-1:0] lamps_q;

    logic [N_PHASES-1:0] demand, owner_mask, grant_mask, pending_d;
    logic [PW-1:0]       grant, idx;
    logic                grant_ok, others;
    logic                go_green, go_yellow, go_allred, go_idle;
    logic [CNT_W-1:0]    timer_cap;

    // Phase 0 ends up in the MSBs because each later phase is shifted in below it.
    function automatic logic [3*N_PHASES-1:0] lamp_vec(input state_e st, input logic [PW-1:0] ph);
        logic [3*N_PHASES-1:0] lv;
        logic [2:0]            code;
        lv = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            code = 3'b001;
            if (PW'(i) == ph && st == StGreen) begin
                code = 3'b100;
            end else if (PW'(i) == ph && st == StYellow) begin
                code = 3'b010;
            end
            lv = {lv[3*N_PHASES-4:0], code};
        end
        return lv;
    endfunction

    always_comb begin
        demand     = pending_q | req;
        owner_mask = N_PHASES'(1) << phase_q;
        others     = |(demand & ~owner_mask);

        // Round-robin scan starting just after the last phase served.
        grant_ok = 1'b0;
        grant    = '0;
        idx      = last_q;
        for (int k = 0; k < N_PHASES; k++) begin
            idx = (idx == PW'(N_PHASES - 1)) ? '0 : idx + 1'b1;
            if (!grant_ok && demand[idx]) begin
                grant_ok = 1'b1;
                grant    = idx;
            end
        end
        grant_mask = N_PHASES'(1) << grant;

        go_green  = 1'b0;
        go_yellow = 1'b0;
        go_allred = 1'b0;
        go_idle   = 1'b0;
        timer_cap = '0;
        unique case (state_q)
            StIdle: go_green = grant_ok;
            StGreen: begin
                timer_cap = GreenMaxM1;
                go_yellow = tick && others &&
                            ((timer_q >= GreenMinM1 && !req[phase_q]) || timer_q == GreenMaxM1);
            end
            StYellow: begin
                timer_cap = YellowM1;
                go_allred = tick && timer_q == YellowM1;
            end
            StAllred: begin
                timer_cap = AllredM1;
                if (tick && timer_q == AllredM1) begin
                    go_green = grant_ok;
                    go_idle  = !grant_ok;
                end
            end
        endcase

        pending_d = pending_q | req;
        if (state_q == StGreen) begin
            pending_d = pending_d & ~owner_mask;
        end
        if (go_green) begin
            pending_d = pending_d & ~grant_mask;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            last_q    <= PW'(N_PHASES - 1);
            pending_q <= '0;
            timer_q   <= '0;
            lamps_q   <= AllRed;
        end else begin
            pending_q <= pending_d;
            if (go_green) begin
                state_q <= StGreen;
                phase_q <= grant;
                last_q  <= grant;
                timer_q <= '0;
                lamps_q <= lamp_vec(StGreen, grant);
            end else if (go_yellow) begin
                state_q <= StYellow;
                timer_q <= '0;
                lamps_q <= lamp_vec(StYellow, phase_q);
            end else if (go_allred) begin
                state_q <= StAllred;
                timer_q <= '0;
                lamps_q <= AllRed;
            end else if (go_idle) begin
                state_q <= StIdle;
                timer_q <= '0;
                lamps_q <= AllRed;
            end else if (tick && timer_q < timer_cap) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    assign lamps = lamps_q;
    assign phase = phase_q;
    assign state = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized and directed bench for traffic_phase_ctrl against a tick-counting reference model.
module tb_traffic_phase_ctrl;

    localparam int NP   = 4;
    localparam int CW   = 8;
    localparam int GMIN = 4;
    localparam int GMAX = 16;
    localparam int YT   = 3;
    localparam int AT   = 1;

    localparam logic [11:0] ALL_RED = 12'b001_001_001_001;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic [NP-1:0] req;
    logic [11:0]   lamps;
    logic [1:0]    phase;
    logic [1:0]    state;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 idle, 1 green, 2 yellow, 3 all-red; m_ticks counts ticks seen in the current state.
    int m_state, m_owner, m_last, m_ticks;
    bit m_pend[NP];
    int order[$];

    always #5 clk = ~clk;

    traffic_phase_ctrl #(
        .N_PHASES (NP),
        .CNT_W    (CW),
        .GREEN_MIN(GMIN),
        .GREEN_MAX(GMAX),
        .YELLOW_T (YT),
        .ALLRED_T (AT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .tick (tick),
        .req  (req),
        .lamps(lamps),
        .phase(phase),
        .state(state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_owner = 0;
        m_last  = NP - 1;
        m_ticks = 0;
        for (int i = 0; i < NP; i++) m_pend[i] = 1'b0;
    endtask

    task automatic model_step(input logic [NP-1:0] r, input logic t);
        bit dem[NP];
        int g, nxt, n, p;
        bit others;
        for (int i = 0; i < NP; i++) dem[i] = m_pend[i] || r[i];
        g = -1;
        for (int k = 1; k <= NP; k++) begin
            p = (m_last + k) % NP;
            if (g < 0 && dem[p]) g = p;
        end
        others = 1'b0;
        for (int i = 0; i < NP; i++) if (i != m_owner && dem[i]) others = 1'b1;
        n   = m_ticks + 1;
        nxt = m_state;
        case (m_state)
            0: if (g >= 0) nxt = 1;
            1: if (t && others && ((n >= GMIN && !r[m_owner]) || n >= GMAX)) nxt = 2;
            2: if (t && n >= YT) nxt = 3;
            3: if (t && n >= AT) nxt = (g >= 0) ? 1 : 0;
            default: nxt = 0;
        endcase
        for (int i = 0; i < NP; i++) begin
            if (r[i] && !(m_state == 1 && i == m_owner)) m_pend[i] = 1'b1;
        end
        if (nxt != m_state) begin
            m_ticks = 0;
            if (nxt == 1) begin
                m_owner   = g;
                m_last    = g;
                m_pend[g] = 1'b0;
            end
        end else if (t) begin
            m_ticks = n;
        end
        m_state = nxt;
    endtask

    function automatic logic [11:0] exp_lamps();
        logic [11:0] lv;
        logic [2:0]  code;
        lv = '0;
        for (int i = 0; i < NP; i++) begin
            code = 3'b001;
            if (i == m_owner && m_state == 1) code = 3'b100;
            if (i == m_owner && m_state == 2) code = 3'b010;
            lv = {lv[8:0], code};
        end
        return lv;
    endfunction

    task automatic cycle(input logic [NP-1:0] r, input logic t);
        req  = r;
        tick = t;
        @(posedge clk);
        if (reset) model_step(r, t);
        #1;
        check("lamps", 32'(lamps), 32'(exp_lamps()));
        check("state", 32'(state), 32'(m_state));
        check("phase", 32'(phase), 32'(m_owner));
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic ticks_until(input logic [1:0] target, input logic [NP-1:0] r, output int n);
        n = 0;
        while (state !== target && n < 200) begin
            cycle(r, 1'b1);
            n++;
        end
    endtask

    task automatic run_rr(input bit repulse);
        bit            pulsed;
        logic [1:0]    prev;
        logic [NP-1:0] r;
        int            guard, want;
        pulsed = 1'b0;
        guard  = 0;
        want   = repulse ? 5 : 4;
        apply_reset();
        order.delete();
        prev = state;
        cycle(4'b1111, 1'b0);
        if (state == 2'b01 && prev != 2'b01) order.push_back(int'(phase));
        while (order.size() < want && guard < 400) begin
            r = '0;
            if (repulse && !pulsed && state == 2'b10 && phase == 2'd0) begin
                r      = 4'b0001;
                pulsed = 1'b1;
            end
            prev = state;
            cycle(r, 1'b1);
            if (state == 2'b01 && prev != 2'b01) order.push_back(int'(phase));
            guard++;
        end
        check("rr_count", 32'(order.size()), 32'(want));
        for (int k = 0; k < order.size() && k < want; k++) begin
            check("rr_order", 32'(order[k]), 32'(k % 4));
        end
    endtask

    initial begin
        int            n;
        logic [NP-1:0] r;
        logic          t;

        reset = 1'b0;
        req   = '0;
        tick  = 1'b0;
        #1;
        apply_reset();

        // Idle with ticks running.
        repeat (50) cycle('0, 1'b1);
        check("idle_state", 32'(state), 32'(2'b00));
        check("idle_lamps", 32'(lamps), 32'(ALL_RED));

        // Single one-cycle request, then rest in green.
        cycle(4'b0010, 1'b0);
        check("single_lamps", 32'(lamps), 32'(12'b001_100_001_001));
        check("single_phase", 32'(phase), 32'd1);
        repeat (20) cycle('0, 1'b1);
        check("rest_green", 32'(state), 32'(2'b01));

        // Minimum green, yellow and all-red clearance.
        apply_reset();
        cycle(4'b0010, 1'b0);
        cycle(4'b1000, 1'b0);
        ticks_until(2'b10, '0, n);
        check("min_green_ticks", 32'(n), 32'(GMIN));
        ticks_until(2'b11, '0, n);
        check("yellow_ticks", 32'(n), 32'(YT));
        check("allred_lamps", 32'(lamps), 32'(ALL_RED));
        ticks_until(2'b01, '0, n);
        check("allred_ticks", 32'(n), 32'(AT));
        check("next_phase", 32'(phase), 32'd3);
        check("next_lamps", 32'(lamps), 32'(12'b001_001_001_100));

        // Extension: held owner request runs green to the maximum.
        apply_reset();
        cycle(4'b0001, 1'b0);
        cycle(4'b0101, 1'b0);
        ticks_until(2'b10, 4'b0001, n);
        check("ext_ticks", 32'(n), 32'(GMAX));

        // Round-robin order, with and without an owner re-request in yellow.
        run_rr(1'b0);
        run_rr(1'b1);

        // Asynchronous reset in the middle of yellow.
        apply_reset();
        cycle(4'b0010, 1'b0);
        cycle(4'b0001, 1'b0);
        ticks_until(2'b10, '0, n);
        check("pre_reset_yellow", 32'(state), 32'(2'b10));
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_state", 32'(state), 32'(2'b00));
        check("async_lamps", 32'(lamps), 32'(ALL_RED));
        cycle('0, 1'b0);
        cycle('0, 1'b1);
        reset = 1'b1;
        repeat (20) cycle('0, 1'b1);
        check("post_reset_idle", 32'(state), 32'(2'b00));

        // Randomized traffic with random ticks and occasional owner extension.
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            r = NP'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) r = r | (NP'(1) << phase);
            t = ($urandom_range(0, 2) != 0);
            cycle(r, t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Parametrised N-phase traffic-light controller; successor to the fixed 4-approach intersection FSM.
- Latches approach requests and serves them round-robin.
- Enforces timed green (min/max with extension), yellow and all-red clearance against an external timebase tick.
- Sits between the switch/debounce front end and the lamp driver; lamp bus keeps the existing 3-bit {G,Y,R} per-approach encoding.

Parameters:
- N_PHASES, 4, number of approaches/phases (legal 2..8).
- CNT_W, 8, width of the dwell timer.
- GREEN_MIN, 4, minimum green in ticks (1 <= GREEN_MIN <= GREEN_MAX).
- GREEN_MAX, 16, maximum green in ticks while other phases wait (GREEN_MAX < 2^CNT_W).
- YELLOW_T, 3, yellow duration in ticks (>= 1).
- ALLRED_T, 1, all-red clearance in ticks (>= 1).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- tick  in  1  one-cycle timebase strobe; timers advance only on cycles with tick=1.
- req  in  N_PHASES  per-phase demand level; bit i = approach i.
- lamps  out  3*N_PHASES  per phase {G,Y,R}; phase 0 occupies the MSBs, phase i at bits [3*(N_PHASES-i)-1 -: 3].
- phase  out  $clog2(N_PHASES)  index of the phase currently owning green/yellow (last granted while in all-red).
- state  out  2  00 IDLE, 01 GREEN, 10 YELLOW, 11 ALLRED.

Behaviour:
- Reset (reset=0, async): state=IDLE, all lamps 001, phase=0, pending=0, timer=0, last_served=N_PHASES-1 so phase 0 wins first arbitration.
- Pending: pending[i] set on any cycle with req[i]=1, except that phase's own bit while it is GREEN. Cleared on the cycle the phase enters GREEN.
- Arbitration: among pending|req, first set bit scanning from last_served+1 upward with wrap to 0.
- Outputs registered: lamps/state/phase change on the clock edge of the transition, with no combinational path from req.
- Lamp rule: owner phase shows 100 (GREEN) or 010 (YELLOW); every other phase, and all phases in IDLE/ALLRED, shows 001. Never two non-red phases.
- Timer: cleared to 0 on every state entry. Increments on tick. Saturates at GREEN_MAX-1 in GREEN, otherwise at the state's terminal value.
- IDLE: no pending/req -> stay. Otherwise, on the next clk (tick not required) -> GREEN for the arbitrated phase; last_served <= phase.
- GREEN: others = pending/req for any phase != owner.
  - No others -> rest in green indefinitely.
  - With others, on a tick cycle -> YELLOW when (timer >= GREEN_MIN-1 and req[owner]=0), or when timer == GREEN_MAX-1.
  - Owner req held acts as extension up to GREEN_MAX.
- YELLOW: on tick with timer == YELLOW_T-1 -> ALLRED.
- ALLRED: on tick with timer == ALLRED_T-1 -> GREEN for the next arbitrated phase if any is pending, else IDLE.
- Owner re-request: if the owner's own req reappears in YELLOW/ALLRED, it is latched. It is served again only after any other pending phase (round-robin fairness).
- Simultaneous tick and new request in ALLRED: the request participates in that cycle's arbitration.
- Reset mid-cycle (any state): immediate all-red, pending cleared. No yellow is generated.
- tick held high continuously is legal: the timer counts every clk.

Test Plan:
- Reset with all req=0, ticks running: lamps=12'b001_001_001_001, state=00, phase=0 for 50 cycles.
- Single request: req=0010 pulsed 1 cycle from IDLE -> next clk GREEN phase=1, lamps=001_100_001_001. Phase rests green with no further requests.
- Min green and clearance: phase 1 green, req[3] pulsed with req[1]=0 at timer=0.
  - Yellow after 4 ticks, ALLRED after 3 more, phase 3 GREEN after 1 more.
  - All-red lamps=001_001_001_001 in between.
- Extension: phase 0 green, req[0] held, req[2] pending -> yellow exactly at tick 16 (GREEN_MAX), not at 4.
- Round-robin: all four req pulsed together in IDLE -> grant order 0,1,2,3. Re-pulsing req[0] during phase 0 yellow gives order 1,2,3,0.
- Async reset asserted in mid-YELLOW between clk edges -> lamps all 001 and state=00 immediately. After release with no req, controller stays IDLE.
